flash_line_buffer: RTL and testbench

Single-line read prefetch buffer between the PicoRV32 instruction/data read port and the `spimemio` flash read port. A miss fetches a whole aligned line of `LINE_WORDS` 32-bit words over the `valid`/`ready` flash interface, one word per transfer, and then answers the CPU. Later reads that hit the same line return in one cycle with no flash traffic. Hit and miss counters support firmware profiling.

---
 rtl/flash_line_buffer.sv | 162 ++++++++++++++++
 tb/tb_flash_line_buffer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/flash_line_buffer.sv
// rtl/flash_line_buffer.sv - single-line read prefetch buffer between the CPU read port and spimemio
module flash_line_buffer #(
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_valid,
  output logic        cpu_ready,
  input  logic [23:0] cpu_addr,
  output logic [31:0] cpu_rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [23:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        flush,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int TAG_W = 22 - IDX_W;

  typedef enum logic [1:0] {IDLE, REQ, GAP, RESP} state_t;

  state_t             state, state_nxt;
  logic [31:0]        line_buf [LINE_WORDS];
  logic [TAG_W-1:0]   tag, tag_nxt;
  logic [IDX_W-1:0]   widx, widx_nxt;
  logic [IDX_W-1:0]   k, k_nxt, k_inc;
  logic               line_valid, line_valid_nxt;
  logic               flush_pend, flush_pend_nxt;
  logic               cpu_ready_nxt;
  logic [31:0]        cpu_rdata_nxt;
  logic               mem_valid_nxt;
  logic [23:0]        mem_addr_nxt;
  logic [15:0]        hit_nxt, miss_nxt;
  logic               buf_we;

  logic [TAG_W-1:0]   req_tag;
  logic [IDX_W-1:0]   req_idx;
  logic               accept, hit, take, last_word;

  assign req_tag   = cpu_addr[23:2+IDX_W];
  assign req_idx   = cpu_addr[1+IDX_W:2];
  // A request still visible while cpu_ready is high is the one just completed.
  assign accept    = cpu_valid && !cpu_ready;
  assign hit       = line_valid && (tag == req_tag) && !flush;
  assign take      = mem_valid && mem_ready;
  assign k_inc     = k + IDX_W'(1);
  assign last_word = (k == IDX_W'(LINE_WORDS - 1));

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && !hit) state_nxt = REQ;
      REQ:  if (take) state_nxt = GAP;
      GAP:  state_nxt = last_word ? RESP : REQ;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cpu_ready_nxt  = 1'b0;
    cpu_rdata_nxt  = cpu_rdata;
    mem_valid_nxt  = mem_valid;
    mem_addr_nxt   = mem_addr;
    tag_nxt        = tag;
    widx_nxt       = widx;
    k_nxt          = k;
    line_valid_nxt = line_valid;
    flush_pend_nxt = flush_pend;
    hit_nxt        = hit_count;
    miss_nxt       = miss_count;
    buf_we         = 1'b0;
    case (state)
      IDLE: begin
        flush_pend_nxt = 1'b0;
        if (flush) line_valid_nxt = 1'b0;
        if (accept) begin
          if (hit) begin
            cpu_rdata_nxt = line_buf[req_idx];
            cpu_ready_nxt = 1'b1;
            hit_nxt       = sat_inc(hit_count);
          end else begin
            line_valid_nxt = 1'b0;
            tag_nxt        = req_tag;
            widx_nxt       = req_idx;
            k_nxt          = '0;
            miss_nxt       = sat_inc(miss_count);
            mem_addr_nxt   = {req_tag, {IDX_W{1'b0}}, 2'b00};
          end
        end
      end
      REQ: begin
        if (flush) flush_pend_nxt = 1'b1;
        mem_valid_nxt = !take;
        buf_we        = take;
      end
      GAP: begin
        // Address advances while mem_valid is low so it never moves under an active request.
        if (flush) flush_pend_nxt = 1'b1;
        mem_valid_nxt = 1'b0;
        if (!last_word) begin
          k_nxt        = k_inc;
          mem_addr_nxt = {tag, k_inc, 2'b00};
        end
      end
      RESP: begin
        line_valid_nxt = !(flush_pend || flush);
        flush_pend_nxt = 1'b0;
        if (cpu_valid) begin
          cpu_rdata_nxt = line_buf[widx];
          cpu_ready_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cpu_ready  <= 1'b0;
      cpu_rdata  <= '0;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      tag        <= '0;
      widx       <= '0;
      k          <= '0;
      line_valid <= 1'b0;
      flush_pend <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      cpu_ready  <= cpu_ready_nxt;
      cpu_rdata  <= cpu_rdata_nxt;
      mem_valid  <= mem_valid_nxt;
      mem_addr   <= mem_addr_nxt;
      tag        <= tag_nxt;
      widx       <= widx_nxt;
      k          <= k_nxt;
      line_valid <= line_valid_nxt;
      flush_pend <= flush_pend_nxt;
      hit_count  <= hit_nxt;
      miss_count <= miss_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) line_buf[k] <= mem_rdata;
  end

endmodule

// File: tb/tb_flash_line_buffer.sv
// tb/tb_flash_line_buffer.sv - directed and random reads against a line-level reference model
module tb_flash_line_buffer;
  localparam int LW = 4;
  localparam int LINE_BYTES = 4 * LW;

  logic        clk = 1'b0;
  logic        resetn, cpu_valid, cpu_ready, mem_valid, mem_ready, flush;
  logic [23:0] cpu_addr, mem_addr;
  logic [31:0] cpu_rdata, mem_rdata;
  logic [15:0] hit_count, miss_count;

  int errors = 0;
  int checks = 0;

  logic [23:0] fetched[$];
  int          lat = 0, cnt = 0;
  logic        prev_ready = 1'b0, prev_mv = 1'b0;
  logic [23:0] prev_ma = '0;

  logic        m_valid;
  int          m_base, m_hits, m_misses;

  flash_line_buffer #(.LINE_WORDS(LW)) dut (
    .clk(clk), .resetn(resetn), .cpu_valid(cpu_valid), .cpu_ready(cpu_ready),
    .cpu_addr(cpu_addr), .cpu_rdata(cpu_rdata), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .flush(flush), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Flash returns its own word address as data after a random wait.
  always @(negedge clk) begin
    if (!mem_valid) begin
      mem_ready = 1'b0;
      cnt = 0;
    end else if (!mem_ready) begin
      if (cnt >= lat) begin
        mem_ready = 1'b1;
        mem_rdata = {8'h00, mem_addr};
        fetched.push_back(mem_addr);
        lat = $urandom_range(0, 3);
      end else cnt++;
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      if (cpu_ready) chk("ready_single_cycle", {31'd0, prev_ready}, 32'd0);
      if (mem_valid && prev_mv) chk("mem_addr_stable", {8'h0, mem_addr}, {8'h0, prev_ma});
    end
    prev_ready = cpu_ready;
    prev_mv    = mem_valid;
    prev_ma    = mem_addr;
  end

  task automatic model_reset();
    m_valid = 1'b0; m_base = -1; m_hits = 0; m_misses = 0;
  endtask

  // mode 0: plain read, 1: flush with the request, 2: flush pulse mid-fill
  task automatic do_read(input logic [23:0] addr, input int mode);
    int   base, cyc;
    logic exp_hit, done, flushed;
    base    = (int'(addr) / LINE_BYTES) * LINE_BYTES;
    exp_hit = m_valid && (base == m_base) && (mode != 1);
    @(negedge clk);
    fetched.delete();
    cpu_addr  = addr;
    cpu_valid = 1'b1;
    flush     = (mode == 1);
    cyc = 0; done = 1'b0; flushed = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      flush = 1'b0;
      if (mode == 2 && !flushed && fetched.size() >= 2) begin
        flush = 1'b1;
        flushed = 1'b1;
      end
      if (cpu_ready) done = 1'b1;
    end
    cpu_valid = 1'b0;
    flush = 1'b0;
    chk("completed", {31'd0, done}, 32'd1);
    chk("rdata", cpu_rdata, {8'h00, addr[23:2], 2'b00});
    if (exp_hit) begin
      chk("hit_latency", 32'(cyc), 32'd1);
      chk("hit_no_fetch", 32'(fetched.size()), 32'd0);
      m_hits++;
    end else begin
      chk("fill_words", 32'(fetched.size()), 32'(LW));
      for (int i = 0; i < LW && i < fetched.size(); i++)
        chk("fill_addr", {8'h0, fetched[i]}, 32'(base + 4 * i));
      m_misses++;
      m_base  = base;
      m_valid = (mode != 2);
    end
    chk("hit_count", {16'h0, hit_count}, 32'(m_hits));
    chk("miss_count", {16'h0, miss_count}, 32'(m_misses));
  endtask

  initial begin
    int r, guard;
    model_reset();
    mem_ready = 1'b0; mem_rdata = '0;
    resetn = 1'b0; cpu_valid = 1'b1; cpu_addr = 24'h100008; flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_mem_addr", {8'h0, mem_addr}, 32'd0);
    chk("rst_hit", {16'h0, hit_count}, 32'd0);
    chk("rst_miss", {16'h0, miss_count}, 32'd0);
    cpu_valid = 1'b0;
    resetn = 1'b1;

    do_read(24'h100008, 0);
    do_read(24'h10000C, 0);
    do_read(24'h100010, 0);
    do_read(24'h100004, 0);
    chk("replace_misses", {16'h0, miss_count}, 32'd3);
    do_read(24'h100028, 2);
    do_read(24'h100028, 0);
    do_read(24'h100020, 0);
    do_read(24'h100024, 1);

    // Reset pulse while a fill is requesting.
    @(negedge clk);
    cpu_addr = 24'h100040; cpu_valid = 1'b1;
    guard = 0;
    while (!mem_valid && guard < 50) begin @(negedge clk); guard++; end
    chk("mid_fill_reached", {31'd0, mem_valid}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("async_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("async_miss_clr", {16'h0, miss_count}, 32'd0);
    @(negedge clk);
    cpu_valid = 1'b0;
    resetn = 1'b1;
    model_reset();
    do_read(24'h100040, 0);
    do_read(24'h100044, 0);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r == 2) begin
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        m_valid = 1'b0;
      end
      do_read(24'h100000 + 24'(4 * $urandom_range(0, 15)), (r == 0) ? 1 : (r == 1) ? 2 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
